// File: rtl/fir_datapath_if.sv
// Control-unit-to-FIR-datapath bus: coefficient/sample strobes in, filter results and status out.
interface fir_datapath_if #(
  parameter int DATA_W = 32
);
  logic [31:0]       tap_count;
  logic [DATA_W-1:0] coeff_data;
  logic              coeff_data_valid;
  logic [DATA_W-1:0] x_data;
  logic              x_data_valid;
  logic              compute;
  logic              coefficient_loading_complete;
  logic              output_data_valid;
  logic [DATA_W-1:0] output_data;
  logic              overrun;

  modport master (
    output tap_count, coeff_data, coeff_data_valid, x_data, x_data_valid, compute,
    input  coefficient_loading_complete, output_data_valid, output_data, overrun
  );

  modport slave (
    input  tap_count, coeff_data, coeff_data_valid, x_data, x_data_valid, compute,
    output coefficient_loading_complete, output_data_valid, output_data, overrun
  );
endinterface

// File: rtl/fir_datapath.sv
// Sequential one-tap-per-clock FIR multiply-accumulate engine.
// Define FIR_SATURATE_EN to saturate the result to DATA_W instead of wrapping.
module fir_datapath #(
  parameter int MAX_TAPS  = 16,
  parameter int DATA_W    = 32,
  parameter int FRAC_BITS = 0
) (
  input logic            clk,
  input logic            rst,
  fir_datapath_if.slave  bus
);

  localparam int IDX_W  = (MAX_TAPS > 1) ? $clog2(MAX_TAPS) : 1;
  localparam int PROD_W = 2 * DATA_W;
  localparam int ACC_W  = PROD_W + IDX_W;

  typedef enum logic [2:0] {EMPTY, LOAD, READY, MAC, OUT} state_t;

  state_t state, state_nxt;

  logic signed [DATA_W-1:0] coeff [MAX_TAPS];
  logic signed [DATA_W-1:0] dly   [MAX_TAPS];
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [PROD_W-1:0] prod;
  logic [IDX_W-1:0]         idx;
  logic [IDX_W-1:0]         n_last;
  logic [IDX_W-1:0]         n_last_calc;
  logic [DATA_W-1:0]        result;
  logic [DATA_W-1:0]        out_q;
  logic                     overrun_q;
  logic                     complete;
  logic                     out_valid;

  // n_last holds N-1, i.e. tap_count clamped to [1, MAX_TAPS] minus one
  always_comb begin
    if (bus.tap_count == 32'd0)
      n_last_calc = '0;
    else if (bus.tap_count >= 32'(MAX_TAPS))
      n_last_calc = IDX_W'(MAX_TAPS - 1);
    else
      n_last_calc = IDX_W'(bus.tap_count - 32'd1);
  end

  assign prod    = coeff[idx] * dly[idx];
  assign acc_nxt = acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign shifted = acc_nxt >>> FRAC_BITS;

`ifdef FIR_SATURATE_EN
  always_comb begin
    result = shifted[DATA_W-1:0];
    if (!(&shifted[ACC_W-1:DATA_W-1] || ~|shifted[ACC_W-1:DATA_W-1]))
      result = shifted[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
  end
`else
  logic unused_shifted_hi;
  assign unused_shifted_hi = ^shifted[ACC_W-1:DATA_W];
  assign result = shifted[DATA_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    complete  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      EMPTY: begin
        if (bus.coeff_data_valid) state_nxt = (n_last_calc == '0) ? READY : LOAD;
      end
      LOAD: begin
        if (bus.coeff_data_valid && idx == n_last) state_nxt = READY;
      end
      READY: begin
        complete = 1'b1;
        // a coefficient strobe wins over a simultaneous sample
        if (bus.coeff_data_valid)
          state_nxt = (n_last_calc == '0) ? READY : LOAD;
        else if (bus.x_data_valid && bus.compute)
          state_nxt = MAC;
      end
      MAC: begin
        complete = 1'b1;
        if (idx == n_last) state_nxt = OUT;
      end
      OUT: begin
        complete  = 1'b1;
        out_valid = 1'b1;
        state_nxt = READY;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < MAX_TAPS; i++) begin
        coeff[i] <= '0;
        dly[i]   <= '0;
      end
      acc       <= '0;
      idx       <= '0;
      n_last    <= '0;
      out_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      unique case (state)
        EMPTY, READY: begin
          if (bus.coeff_data_valid) begin
            n_last <= n_last_calc;
            for (int unsigned i = 0; i < MAX_TAPS; i++) dly[i] <= '0;
            coeff[0] <= bus.coeff_data;
            idx      <= (n_last_calc == '0) ? '0 : IDX_W'(1);
          end else if (state == READY && bus.x_data_valid) begin
            for (int unsigned i = MAX_TAPS - 1; i > 0; i--) dly[i] <= dly[i-1];
            dly[0] <= bus.x_data;
            if (bus.compute) begin
              idx <= '0;
              acc <= '0;
            end
          end
        end
        LOAD: begin
          if (bus.coeff_data_valid) begin
            coeff[idx] <= bus.coeff_data;
            idx        <= (idx == n_last) ? '0 : idx + 1'b1;
          end
        end
        MAC: begin
          acc <= acc_nxt;
          if (idx == n_last) begin
            out_q <= result;
            idx   <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
      if ((state == MAC || state == OUT) && bus.x_data_valid) overrun_q <= 1'b1;
    end
  end

  assign bus.coefficient_loading_complete = complete;
  assign bus.output_data_valid            = out_valid;
  assign bus.output_data                  = out_q;
  assign bus.overrun                      = overrun_q;

endmodule

// File: tb/tb_fir_datapath.sv
// Directed bench for fir_datapath: expected outputs and their arrival cycles are queued
// when each sample is driven and checked when output_data_valid fires.
module tb_fir_datapath;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  fir_datapath_if #(.DATA_W(32)) bus ();

  fir_datapath #(.MAX_TAPS(16), .DATA_W(32), .FRAC_BITS(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.output_data_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", 64'(sb.size()), 64'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data", bus.output_data, e.data);
        chk("out_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.coeff_data_valid = 1'b0;
    bus.x_data_valid     = 1'b0;
    @(negedge clk);
    sb.delete();
    rst = 1'b0;
  endtask

  task automatic send_coeff(input logic [31:0] v);
    bus.coeff_data       = v;
    bus.coeff_data_valid = 1'b1;
    @(negedge clk);
    bus.coeff_data_valid = 1'b0;
  endtask

  // lat = N+1 for an accepted computing sample; exp_en=0 when no output is due
  task automatic send_sample(input logic [31:0] v, input bit exp_en,
                             input logic [31:0] expv, input int lat);
    exp_t e;
    bus.x_data       = v;
    bus.x_data_valid = 1'b1;
    if (exp_en) begin
      e.data = expv;
      e.cyc  = cyc + lat;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.x_data_valid = 1'b0;
  endtask

  initial begin
    bus.tap_count        = 32'd0;
    bus.coeff_data       = '0;
    bus.coeff_data_valid = 1'b0;
    bus.x_data           = '0;
    bus.x_data_valid     = 1'b0;
    bus.compute          = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    chk("rst_complete", bus.coefficient_loading_complete, 0);
    chk("rst_valid", bus.output_data_valid, 0);
    chk("rst_out", bus.output_data, 0);
    chk("rst_overrun", bus.overrun, 0);

    // N=3, coeffs 1,2,3, samples 10,20,30
    bus.tap_count = 32'd3;
    bus.compute   = 1'b1;
    send_coeff(32'd1);
    send_coeff(32'd2);
    chk("n3_not_complete", bus.coefficient_loading_complete, 0);
    send_coeff(32'd3);
    chk("n3_complete", bus.coefficient_loading_complete, 1);
    send_sample(32'd10, 1'b1, 32'd10, 4);
    wait_cycles(4);
    send_sample(32'd20, 1'b1, 32'd40, 4);
    wait_cycles(4);
    send_sample(32'd30, 1'b1, 32'd100, 4);
    wait_cycles(6);
    chk("hold_out", bus.output_data, 100);
    chk("n3_overrun", bus.overrun, 0);

    // tap_count=0 clamps to N=1
    bus.tap_count = 32'd0;
    send_coeff(32'd5);
    chk("n1_complete", bus.coefficient_loading_complete, 1);
    send_sample(32'd7, 1'b1, 32'd35, 2);
    wait_cycles(2);

    // tap_count=40 clamps to 16
    bus.tap_count = 32'd40;
    for (int k = 1; k <= 15; k++) send_coeff(32'(k));
    chk("n16_not_complete", bus.coefficient_loading_complete, 0);
    send_coeff(32'd16);
    chk("n16_complete", bus.coefficient_loading_complete, 1);
    send_sample(32'd2, 1'b1, 32'd2, 17);
    wait_cycles(17);
    send_sample(32'd3, 1'b1, 32'd7, 17);
    wait_cycles(17);

    // N=4, sample while busy is dropped and flagged
    bus.tap_count = 32'd4;
    for (int k = 0; k < 4; k++) send_coeff(32'd1);
    send_sample(32'd5, 1'b1, 32'd5, 5);
    wait_cycles(1);
    send_sample(32'd1, 1'b0, 32'd0, 0);
    chk("busy_overrun", bus.overrun, 1);
    wait_cycles(3);
    send_sample(32'd2, 1'b1, 32'd7, 5);
    wait_cycles(5);

    // compute=0 stores samples without producing output
    bus.tap_count = 32'd3;
    for (int k = 0; k < 3; k++) send_coeff(32'd1);
    bus.compute = 1'b0;
    send_sample(32'd1, 1'b0, 32'd0, 0);
    send_sample(32'd2, 1'b0, 32'd0, 0);
    wait_cycles(2);
    bus.compute = 1'b1;
    send_sample(32'd3, 1'b1, 32'd6, 4);
    wait_cycles(4);
    chk("overrun_sticky", bus.overrun, 1);

    // result reduction to DATA_W
    bus.tap_count = 32'd1;
    send_coeff(32'h7FFF_FFFF);
`ifdef FIR_SATURATE_EN
    send_sample(32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFF, 2);
`else
    send_sample(32'h7FFF_FFFF, 1'b1, 32'h0000_0001, 2);
`endif
    wait_cycles(2);
    send_coeff(32'h8000_0000);
`ifdef FIR_SATURATE_EN
    send_sample(32'd2, 1'b1, 32'h8000_0000, 2);
`else
    send_sample(32'd2, 1'b1, 32'h0000_0000, 2);
`endif
    wait_cycles(2);

    // reset in the middle of a MAC
    bus.tap_count = 32'd4;
    send_coeff(32'd1);
    send_coeff(32'd2);
    send_coeff(32'd3);
    send_coeff(32'd4);
    send_sample(32'd9, 1'b0, 32'd0, 0);
    chk("mid_mac_overrun_before", bus.overrun, 1);
    do_reset();
    chk("midrst_complete", bus.coefficient_loading_complete, 0);
    chk("midrst_out", bus.output_data, 0);
    chk("midrst_valid", bus.output_data_valid, 0);
    chk("midrst_overrun", bus.overrun, 0);
    wait_cycles(6);
    bus.tap_count = 32'd2;
    send_coeff(32'd1);
    chk("reload_not_complete", bus.coefficient_loading_complete, 0);
    send_coeff(32'd3);
    chk("reload_complete", bus.coefficient_loading_complete, 1);
    send_sample(32'd4, 1'b1, 32'd4, 3);
    wait_cycles(3);
    send_sample(32'd5, 1'b1, 32'd17, 3);
    wait_cycles(6);

    chk("pending_outputs", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fir_datapath.md
# fir_datapath

Sequential multiply-accumulate FIR engine that sits directly downstream of the FIR control unit. It consumes the control unit's coefficient stream, sample stream, tap count and compute enable, and produces one filtered output per accepted sample. Coefficients are held in a MAX_TAPS-deep register bank, and samples are held in a matching shift-register delay line. One tap is evaluated per clock.

## Interface
- MAX_TAPS, 16, depth of the coefficient bank and delay line.
- DATA_W, 32, width of coefficients, samples and output; all are signed two's complement.
- FRAC_BITS, 0, arithmetic right-shift applied to the accumulator before output.

- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- tap_count  in  32  requested number of taps; sampled when coefficient loading starts.
- coeff_data  in  DATA_W  coefficient value.
- coeff_data_valid  in  1  one-cycle strobe that writes coeff_data.
- x_data  in  DATA_W  input sample.
- x_data_valid  in  1  one-cycle strobe that presents x_data.
- compute  in  1  level signal; enables filtering of accepted samples.
- coefficient_loading_complete  out  1  level signal; high while the coefficient bank is fully loaded.
- output_data_valid  out  1  one-cycle pulse; output_data is new.
- output_data  out  DATA_W  last filter result; held between results.
- overrun  out  1  sticky flag; a sample arrived while busy. Cleared only by rst.

## Operation
- Effective tap count N = clamp(tap_count, 1, MAX_TAPS). Zero maps to 1; values above MAX_TAPS map to MAX_TAPS. N is latched on the first coefficient write of a load.
- States:
  - EMPTY: reset state. The first coeff_data_valid latches N, clears the delay line, writes c[0] and goes to LOAD. If N=1, it goes straight to READY instead.
  - LOAD: each coeff_data_valid writes c[idx] and increments idx. The write of c[N-1] moves the block to READY. x_data_valid is ignored.
  - READY: coefficient_loading_complete=1. On x_data_valid, x_data shifts into d[0] and older samples move to d[i+1]; the oldest sample is discarded.
    - If compute=1, the block goes to MAC with i=0 and acc=0.
    - If compute=0, the sample is stored and no output is produced.
    - A coeff_data_valid in READY starts a reload: N re-latched, delay line cleared, c[0] written, complete deasserted. The next state is LOAD, or READY if N=1.
  - MAC: acc += c[i]*d[i] for i = 0..N-1, one product per cycle. After i=N-1 the block goes to OUT.
  - OUT: output_data is registered, output_data_valid pulses, and the block returns to READY.
- Behaviour in MAC/OUT:
  - x_data_valid is dropped (no shift) and sets overrun.
  - coeff_data_valid is ignored.
  - compute falling mid-MAC does not abort; the result is still produced.
- Arithmetic:
  - Each product is full 2*DATA_W-bit signed.
  - acc is 2*DATA_W+clog2(MAX_TAPS) bits, so it cannot overflow.
  - The result is acc >>> FRAC_BITS (arithmetic shift), reduced to DATA_W per Configuration.
- Reset (including mid-MAC or mid-LOAD):
  - State returns to EMPTY.
  - Coefficients, delay line, acc, output_data, overrun and idx are all cleared to 0.
  - coefficient_loading_complete=0 and output_data_valid=0.

## Timing
- Coefficient write at edge k updates the bank at edge k.
- coefficient_loading_complete rises in the cycle after the c[N-1] write. Back-to-back coefficient strobes are allowed.
- x_data_valid with compute=1 in cycle T:
  - The delay line updates at the end of T.
  - MAC runs in cycles T+1..T+N.
  - output_data_valid=1 in cycle T+N+1, for exactly one cycle.
  - Latency is N+1 cycles; the next sample is accepted from cycle T+N+2 onward.
- If x_data_valid and coeff_data_valid arrive in the same READY cycle, the coefficient takes priority: reload starts and the sample is dropped without setting overrun.
- output_data changes only on the output_data_valid cycle.

## Configuration
- FIR_SATURATE_EN defined: the shifted result is saturated to the signed DATA_W range, i.e. [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- FIR_SATURATE_EN undefined: the shifted result is truncated to its low DATA_W bits (wrap-around).
- The macro has no effect on latency, state machine or any other behaviour.

## Test plan
- Reset, then tap_count=3, coeffs 1,2,3, compute=1, samples 10,20,30. Required: complete rises after the 3rd coeff write; outputs are 10, 40, 100, each with valid asserted exactly 4 cycles after its sample.
- tap_count=0, one coeff 5, then sample 7. Required: N=1, complete after the first write, output 35 two cycles after the sample. tap_count=40 must load exactly 16 coefficients.
- N=4, sample 1 sent while busy 2 cycles after the first sample. Required: overrun=1, the delay line is unchanged, and exactly one output pulse occurs.
- compute=0 with samples 1,2, then compute=1 with sample 3, coeffs 1,1,1. Required: no output for the first two samples, then output 6.
- N=1, FRAC_BITS=0, coeff 0x7FFFFFFF, sample 0x7FFFFFFF. Required: output 0x7FFFFFFF with FIR_SATURATE_EN defined, 0x00000001 without it.
- rst asserted during MAC. Required: the next cycle shows complete=0, output_data=0, no valid pulse, and state EMPTY. A reload after reset must then work from c[0].
